// File: rtl/vga_timing_gen_if.sv
// Video output bundle between the timing generator and the display encoder.
// BLANK is high during active video. RGB is zero whenever BLANK is low.
interface video_if #(
  parameter int RGB_W = 24
);
  logic             CLK;
  logic             HS;
  logic             VS;
  logic             BLANK;
  logic [RGB_W-1:0] RGB;

  modport master (output CLK, output HS, output VS, output BLANK, output RGB);
  modport slave  (input CLK, input HS, input VS, input BLANK, input RGB);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator.
//
// Each line and each frame is ordered front porch, sync, back porch, active.
// pix_req/pix_x/pix_y run one cycle after the counters, so the pixel source
// sees each request PIX_LAT cycles before its data is sampled. Sync, blank,
// frame_start and line_start go through the same delay line as the request,
// so they line up with the returned pixel for any PIX_LAT.
//
// Define VGA_GRID_PATTERN_EN to overlay a 16-pixel white grid on active video.
module vga_timing_gen #(
  parameter int HDISP   = 800,
  parameter int VDISP   = 480,
  parameter int HFP     = 40,
  parameter int HPULSE  = 48,
  parameter int HBP     = 40,
  parameter int VFP     = 13,
  parameter int VPULSE  = 3,
  parameter int VBP     = 29,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int PIX_LAT = 2,
  parameter int RGB_W   = 24
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     enable,
  video_if.master                  video_ifm,
  output logic                     pix_req,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  input  logic [RGB_W-1:0]         pix_data,
  output logic                     frame_start,
  output logic                     line_start
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);
  localparam logic [HW-1:0] H_START    = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_START    = VW'(VFP + VPULSE + VBP);

  // Control word fields carried through the latency-matching delay line
  localparam int F_HS    = 0;
  localparam int F_VS    = 1;
  localparam int F_BLANK = 2;
  localparam int F_FS    = 3;
  localparam int F_LS    = 4;
`ifdef VGA_GRID_PATTERN_EN
  localparam int F_GRID  = 5;
  localparam int CTRL_W  = 6;
`else
  localparam int CTRL_W  = 5;
`endif
  localparam logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'({~VS_POL, ~HS_POL});

  if (PIX_LAT < 0 || PIX_LAT > 8) begin : g_lat_check
    $error("vga_timing_gen: PIX_LAT must be within 0..8");
  end

`ifdef VGA_GRID_PATTERN_EN
  function automatic logic on_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [31:0] xw;
    logic [31:0] yw;
    xw = 32'(x);
    yw = 32'(y);
    return (xw[3:0] == 4'd0) || (yw[3:0] == 4'd0);
  endfunction
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              h_end;
  logic              v_end;

  logic              vld_p0;
  logic              act_p0;
  logic [HW-1:0]     x_off_p0;
  logic [VW-1:0]     y_off_p0;
  logic [CTRL_W-1:0] ctrl_p0;

  logic              pix_req_p1;
  logic [XW-1:0]     pix_x_p1;
  logic [YW-1:0]     pix_y_p1;
  logic [CTRL_W-1:0] ctrl_pn [0:PIX_LAT];
  logic [CTRL_W-1:0] ctrl_s;
  logic [RGB_W-1:0]  pix_sel;

  logic              hs_p2;
  logic              vs_p2;
  logic              blank_p2;
  logic              fs_p2;
  logic              ls_p2;
  logic [RGB_W-1:0]  rgb_p2;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  // Frame FSM and counters: counters only move in RUN; a frame boundary is the only way out
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h_end) begin
            h_cnt <= '0;
            if (v_end) begin
              v_cnt <= '0;
              if (!enable) state <= ST_IDLE;
            end else begin
              v_cnt <= v_cnt + 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: decode the counter position ----
  // Position decode: sync windows, active window and pixel coordinates
  always_comb begin
    vld_p0   = (state == ST_RUN);
    act_p0   = vld_p0 && (h_cnt >= H_START) && (v_cnt >= V_START);
    x_off_p0 = h_cnt - H_START;
    y_off_p0 = v_cnt - V_START;
    ctrl_p0  = '0;
    ctrl_p0[F_HS]    = (vld_p0 && h_cnt >= H_SYNC_BEG && h_cnt < H_SYNC_END) ? HS_POL : ~HS_POL;
    ctrl_p0[F_VS]    = (vld_p0 && v_cnt >= V_SYNC_BEG && v_cnt < V_SYNC_END) ? VS_POL : ~VS_POL;
    ctrl_p0[F_BLANK] = act_p0;
    ctrl_p0[F_FS]    = vld_p0 && (h_cnt == '0) && (v_cnt == '0);
    ctrl_p0[F_LS]    = vld_p0 && (h_cnt == '0);
`ifdef VGA_GRID_PATTERN_EN
    ctrl_p0[F_GRID]  = act_p0 && on_grid(x_off_p0[XW-1:0], y_off_p0[YW-1:0]);
`endif
  end

  // ---- stage p1: registered request, then PIX_LAT cycles of control delay ----
  // Request registers and the delay line that tracks the pixel source latency
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      pix_req_p1 <= 1'b0;
      pix_x_p1   <= '0;
      pix_y_p1   <= '0;
      for (int i = 0; i <= PIX_LAT; i++) ctrl_pn[i] <= CTRL_IDLE;
    end else begin
      pix_req_p1 <= act_p0;
      pix_x_p1   <= act_p0 ? x_off_p0[XW-1:0] : '0;
      pix_y_p1   <= act_p0 ? y_off_p0[YW-1:0] : '0;
      ctrl_pn[0] <= ctrl_p0;
      for (int i = 1; i <= PIX_LAT; i++) ctrl_pn[i] <= ctrl_pn[i-1];
    end
  end

  assign ctrl_s = ctrl_pn[PIX_LAT];

`ifdef VGA_GRID_PATTERN_EN
  assign pix_sel = ctrl_s[F_GRID] ? '1 : pix_data;
`else
  assign pix_sel = pix_data;
`endif

  // ---- stage p2: output register, pixel data meets its delayed control ----
  // Output registers: RGB is forced to zero outside active video
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_p2    <= ~HS_POL;
      vs_p2    <= ~VS_POL;
      blank_p2 <= 1'b0;
      fs_p2    <= 1'b0;
      ls_p2    <= 1'b0;
      rgb_p2   <= '0;
    end else begin
      hs_p2    <= ctrl_s[F_HS];
      vs_p2    <= ctrl_s[F_VS];
      blank_p2 <= ctrl_s[F_BLANK];
      fs_p2    <= ctrl_s[F_FS];
      ls_p2    <= ctrl_s[F_LS];
      rgb_p2   <= ctrl_s[F_BLANK] ? pix_sel : '0;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_p2;
  assign video_ifm.VS    = vs_p2;
  assign video_ifm.BLANK = blank_p2;
  assign video_ifm.RGB   = rgb_p2;
  assign pix_req         = pix_req_p1;
  assign pix_x           = pix_x_p1;
  assign pix_y           = pix_y_p1;
  assign frame_start     = fs_p2;
  assign line_start      = ls_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 14x7 raster (8x4 active).
// Five instances share clock, reset and enable: PIX_LAT 2 (main), 0 and 8,
// inverted polarity, and a 32x20 instance for the grid overlay.
module tb_vga_timing_gen;
  localparam int HT = 14;
  localparam int FR = 98;
  localparam int GHT = 38;
  localparam int GFR = 38 * 23;
  localparam int BIG = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // main: PIX_LAT=2, active-low syncs
  video_if #(.RGB_W(24)) vm ();
  logic m_req, m_fs, m_ls; logic [2:0] m_x; logic [1:0] m_y; logic [23:0] m_data;
  vga_timing_gen #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
    .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .RGB_W(24)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .video_ifm(vm), .pix_req(m_req),
    .pix_x(m_x), .pix_y(m_y), .pix_data(m_data), .frame_start(m_fs), .line_start(m_ls));

  // PIX_LAT=0
  video_if #(.RGB_W(24)) vz ();
  logic z_req, z_fs, z_ls; logic [2:0] z_x; logic [1:0] z_y; logic [23:0] z_data;
  vga_timing_gen #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
    .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(0), .RGB_W(24)) dut_l0 (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .video_ifm(vz), .pix_req(z_req),
    .pix_x(z_x), .pix_y(z_y), .pix_data(z_data), .frame_start(z_fs), .line_start(z_ls));

  // PIX_LAT=8
  video_if #(.RGB_W(24)) ve ();
  logic e_req, e_fs, e_ls; logic [2:0] e_x; logic [1:0] e_y; logic [23:0] e_data;
  vga_timing_gen #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
    .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(8), .RGB_W(24)) dut_l8 (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .video_ifm(ve), .pix_req(e_req),
    .pix_x(e_x), .pix_y(e_y), .pix_data(e_data), .frame_start(e_fs), .line_start(e_ls));

  // PIX_LAT=2, active-high syncs
  video_if #(.RGB_W(24)) vp ();
  logic p_req, p_fs, p_ls; logic [2:0] p_x; logic [1:0] p_y; logic [23:0] p_data;
  vga_timing_gen #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
    .VBP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(2), .RGB_W(24)) dut_pol (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .video_ifm(vp), .pix_req(p_req),
    .pix_x(p_x), .pix_y(p_y), .pix_data(p_data), .frame_start(p_fs), .line_start(p_ls));

  // 32x20 active, pix_data tied to zero
  video_if #(.RGB_W(24)) vg ();
  logic g_req, g_fs, g_ls; logic [4:0] g_x; logic [4:0] g_y; logic [23:0] g_data;
  vga_timing_gen #(.HDISP(32), .VDISP(20), .HFP(2), .HPULSE(2), .HBP(2), .VFP(1), .VPULSE(1),
    .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .RGB_W(24)) dut_grid (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .video_ifm(vg), .pix_req(g_req),
    .pix_x(g_x), .pix_y(g_y), .pix_data(g_data), .frame_start(g_fs), .line_start(g_ls));

  // Pixel sources returning {y, x} after each instance's latency
  logic [4:0] m_dl [0:1];
  logic [4:0] p_dl [0:1];
  logic [4:0] e_dl [0:7];
  always @(posedge clk) begin
    m_dl[0] <= {m_y, m_x}; m_dl[1] <= m_dl[0];
    p_dl[0] <= {p_y, p_x}; p_dl[1] <= p_dl[0];
    e_dl[0] <= {e_y, e_x};
    for (int i = 1; i < 8; i++) e_dl[i] <= e_dl[i-1];
  end
  assign m_data = {19'd0, m_dl[1]};
  assign p_data = {19'd0, p_dl[1]};
  assign e_data = {19'd0, e_dl[7]};
  assign z_data = {19'd0, z_y, z_x};
  assign g_data = 24'd0;

  // Expected {HS, VS, BLANK, frame_start, line_start, RGB} for frame position n
  function automatic logic [28:0] exp_vid(input int n, input int nmax, input bit hp, input bit vp);
    int m, h, v;
    logic act;
    logic [2:0] x;
    logic [1:0] y;
    if (n < 0 || n >= nmax) return {~hp, ~vp, 3'b000, 24'h0};
    m = n % FR; h = m % HT; v = m / HT;
    act = (h >= 6) && (v >= 3);
    x = 3'(h - 6); y = 2'(v - 3);
    return {((h >= 2 && h < 4) ? hp : ~hp), ((v == 1) ? vp : ~vp), act, (m == 0), (h == 0),
            act ? {19'd0, y, x} : 24'h0};
  endfunction

  // Expected {pix_req, pix_x, pix_y} for frame position n
  function automatic logic [5:0] exp_pix(input int n, input int nmax);
    int m, h, v;
    logic [2:0] x;
    logic [1:0] y;
    if (n < 0 || n >= nmax) return 6'd0;
    m = n % FR; h = m % HT; v = m / HT;
    if (h < 6 || v < 3) return 6'd0;
    x = 3'(h - 6); y = 2'(v - 3);
    return {1'b1, x, y};
  endfunction

  // Expected {BLANK, RGB} for the grid instance
  function automatic logic [24:0] exp_grid(input int n);
    int h, v, x, y;
    logic act;
    if (n < 0 || n >= GFR) return 25'd0;
    h = n % GHT; v = n / GHT;
    act = (h >= 6) && (v >= 3);
    x = h - 6; y = v - 3;
`ifdef VGA_GRID_PATTERN_EN
    if (act && (x % 16 == 0 || y % 16 == 0)) return {1'b1, 24'hFFFFFF};
`endif
    return {act, 24'h0};
  endfunction

  task automatic hold_reset();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== {5'b11000, 24'h0}) begin
      failures++;
      $display("FAIL reset_main_vid got=%h exp=%h", {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, {5'b11000, 24'h0});
    end
    checks++;
    if ({m_req, m_x, m_y} !== 6'd0) begin
      failures++;
      $display("FAIL reset_main_pix got=%h exp=0", {m_req, m_x, m_y});
    end
    checks++;
    if ({vp.HS, vp.VS, vp.BLANK, vp.RGB} !== {3'b000, 24'h0}) begin
      failures++;
      $display("FAIL reset_pol_vid got=%h exp=0", {vp.HS, vp.VS, vp.BLANK, vp.RGB});
    end
    checks++;
    if (vm.CLK !== clk) begin
      failures++;
      $display("FAIL reset_clk got=%b exp=%b", vm.CLK, clk);
    end
  endtask

  task automatic test_run_timing();
    int hs_lo = 0, vs_lo = 0, bl = 0, rq = 0;
    int fr_m = 0, fb_m = 0, fr_z = 0, fb_z = 0, fr_e = 0, fb_e = 0;
    logic [28:0] ev;
    logic [5:0] ep;
    rst = 1'b0;
    for (int k = 1; k <= 2 * FR + 20; k++) begin
      @(posedge clk); @(negedge clk);
      ev = exp_vid(k - 5, BIG, 1'b0, 1'b0);
      checks++;
      if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== ev) begin
        failures++;
        $display("FAIL run_main_vid k=%0d got=%h exp=%h", k, {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, ev);
      end
      ep = exp_pix(k - 2, BIG);
      checks++;
      if ({m_req, m_x, m_y} !== ep) begin
        failures++;
        $display("FAIL run_main_pix k=%0d got=%h exp=%h", k, {m_req, m_x, m_y}, ep);
      end
      ev = exp_vid(k - 3, BIG, 1'b0, 1'b0);
      checks++;
      if ({vz.HS, vz.VS, vz.BLANK, z_fs, z_ls, vz.RGB} !== ev) begin
        failures++;
        $display("FAIL run_lat0_vid k=%0d got=%h exp=%h", k, {vz.HS, vz.VS, vz.BLANK, z_fs, z_ls, vz.RGB}, ev);
      end
      ev = exp_vid(k - 11, BIG, 1'b0, 1'b0);
      checks++;
      if ({ve.HS, ve.VS, ve.BLANK, e_fs, e_ls, ve.RGB} !== ev) begin
        failures++;
        $display("FAIL run_lat8_vid k=%0d got=%h exp=%h", k, {ve.HS, ve.VS, ve.BLANK, e_fs, e_ls, ve.RGB}, ev);
      end
      ev = exp_vid(k - 5, BIG, 1'b1, 1'b1);
      checks++;
      if ({vp.HS, vp.VS, vp.BLANK, p_fs, p_ls, vp.RGB} !== ev) begin
        failures++;
        $display("FAIL run_pol_vid k=%0d got=%h exp=%h", k, {vp.HS, vp.VS, vp.BLANK, p_fs, p_ls, vp.RGB}, ev);
      end
      checks++;
      if ({p_req, p_x, p_y} !== exp_pix(k - 2, BIG)) begin
        failures++;
        $display("FAIL run_pol_pix k=%0d got=%h exp=%h", k, {p_req, p_x, p_y}, exp_pix(k - 2, BIG));
      end
      if (k >= 5 && k < 5 + FR) begin
        if (vm.HS == 1'b0) hs_lo++;
        if (vm.VS == 1'b0) vs_lo++;
        if (vm.BLANK == 1'b1) bl++;
      end
      if (k >= 2 && k < 2 + FR && m_req) rq++;
      if (fr_m == 0 && m_req) fr_m = k;
      if (fb_m == 0 && vm.BLANK) fb_m = k;
      if (fr_z == 0 && z_req) fr_z = k;
      if (fb_z == 0 && vz.BLANK) fb_z = k;
      if (fr_e == 0 && e_req) fr_e = k;
      if (fb_e == 0 && ve.BLANK) fb_e = k;
    end
    checks++;
    if (hs_lo != 14) begin failures++; $display("FAIL hs_low_count got=%0d exp=14", hs_lo); end
    checks++;
    if (vs_lo != 14) begin failures++; $display("FAIL vs_low_count got=%0d exp=14", vs_lo); end
    checks++;
    if (bl != 32) begin failures++; $display("FAIL blank_count got=%0d exp=32", bl); end
    checks++;
    if (rq != 32) begin failures++; $display("FAIL pix_req_count got=%0d exp=32", rq); end
    checks++;
    if (fb_m - fr_m != 3) begin failures++; $display("FAIL first_rgb_lat2 got=%0d exp=3", fb_m - fr_m); end
    checks++;
    if (fb_z - fr_z != 1) begin failures++; $display("FAIL first_rgb_lat0 got=%0d exp=1", fb_z - fr_z); end
    checks++;
    if (fb_e - fr_e != 9) begin failures++; $display("FAIL first_rgb_lat8 got=%0d exp=9", fb_e - fr_e); end
  endtask

  task automatic test_enable_drop();
    int fs_cnt = 0;
    logic [28:0] ev;
    en = 1'b1;
    hold_reset();
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk); @(negedge clk);
      ev = exp_vid(k - 5, FR, 1'b0, 1'b0);
      checks++;
      if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== ev) begin
        failures++;
        $display("FAIL drop_vid k=%0d got=%h exp=%h", k, {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, ev);
      end
      checks++;
      if ({m_req, m_x, m_y} !== exp_pix(k - 2, FR)) begin
        failures++;
        $display("FAIL drop_pix k=%0d got=%h exp=%h", k, {m_req, m_x, m_y}, exp_pix(k - 2, FR));
      end
      if (k == 21) en = 1'b0;
    end
    en = 1'b1;
    for (int k = 131; k <= 300; k++) begin
      @(posedge clk); @(negedge clk);
      ev = exp_vid(k - 135, BIG, 1'b0, 1'b0);
      checks++;
      if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== ev) begin
        failures++;
        $display("FAIL restart_vid k=%0d got=%h exp=%h", k, {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, ev);
      end
      if (m_fs) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 2) begin failures++; $display("FAIL restart_fs_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [28:0] ev;
    en = 1'b1;
    hold_reset();
    for (int k = 1; k <= 51; k++) begin
      @(posedge clk); @(negedge clk);
      ev = exp_vid(k - 5, BIG, 1'b0, 1'b0);
      checks++;
      if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== ev) begin
        failures++;
        $display("FAIL pre_rst_vid k=%0d got=%h exp=%h", k, {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, ev);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== {5'b11000, 24'h0}) begin
      failures++;
      $display("FAIL midrst_vid got=%h exp=%h", {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, {5'b11000, 24'h0});
    end
    checks++;
    if ({m_req, m_x, m_y} !== 6'd0) begin
      failures++;
      $display("FAIL midrst_pix got=%h exp=0", {m_req, m_x, m_y});
    end
    checks++;
    if ({vp.HS, vp.VS, vp.BLANK, vp.RGB} !== 27'd0) begin
      failures++;
      $display("FAIL midrst_pol got=%h exp=0", {vp.HS, vp.VS, vp.BLANK, vp.RGB});
    end
    hold_reset();
    for (int k = 1; k <= FR + 10; k++) begin
      @(posedge clk); @(negedge clk);
      ev = exp_vid(k - 5, BIG, 1'b0, 1'b0);
      checks++;
      if ({vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB} !== ev) begin
        failures++;
        $display("FAIL post_rst_vid k=%0d got=%h exp=%h", k, {vm.HS, vm.VS, vm.BLANK, m_fs, m_ls, vm.RGB}, ev);
      end
      checks++;
      if ({m_req, m_x, m_y} !== exp_pix(k - 2, BIG)) begin
        failures++;
        $display("FAIL post_rst_pix k=%0d got=%h exp=%h", k, {m_req, m_x, m_y}, exp_pix(k - 2, BIG));
      end
    end
  endtask

  task automatic test_grid();
    logic [24:0] eg;
    en = 1'b1;
    hold_reset();
    for (int k = 1; k <= GFR + 4; k++) begin
      @(posedge clk); @(negedge clk);
      eg = exp_grid(k - 5);
      checks++;
      if ({vg.BLANK, vg.RGB} !== eg) begin
        failures++;
        $display("FAIL grid k=%0d got=%h exp=%h", k, {vg.BLANK, vg.RGB}, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_timing();
    test_enable_drop();
    test_reset_midframe();
    test_grid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
